sp_access_ctrl: RTL



---
 rtl/sp_pkg.sv | 19 +
 rtl/sp_dump_fsm.sv | 117 +++++++++++
 rtl/sp_access_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/sp_pkg.sv
// Shared constants and dump FSM state encoding for the result scratchpad
// and its access controller.
package sp_pkg;

  localparam int SP_NTARGETS = 4;
  localparam int DATA_WIDTH  = 32;
  localparam int BUS_WIDTH   = 64;
  localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH;
  localparam int N_WORDS     = MAX_DIM * MAX_DIM;
  localparam int ADDR_W      = 2 * $clog2(MAX_DIM);
  localparam int TGT_W       = 2;

  typedef enum logic [1:0] {
    DUMP_IDLE  = 2'd0,
    DUMP_RUN   = 2'd1,
    DUMP_FLUSH = 2'd2
  } dump_state_e;

endpackage

// File: rtl/sp_dump_fsm.sv
// Streams one whole target matrix out of the scratchpad over valid/ready,
// fetching a word only when the arbiter leaves the port free.
module sp_dump_fsm
  import sp_pkg::*;
#(
  parameter int WORD_W    = 64,
  parameter int IDX_W     = 2,
  parameter int NUM_WORDS = 4,
  parameter int TGT_BITS  = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [TGT_BITS-1:0] target_i,
  input  logic                port_free_i,
  input  logic                ready_i,
  input  logic [WORD_W-1:0]   rdata_i,
  output logic                fetch_o,
  output logic [TGT_BITS-1:0] fetch_target_o,
  output logic [IDX_W-1:0]    fetch_addr_o,
  output logic                busy_o,
  output logic                valid_o,
  output logic [WORD_W-1:0]   data_o,
  output logic                last_o,
  output logic                done_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  dump_state_e         state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TGT_BITS-1:0] tgt_q, tgt_d;
  logic                valid_q, valid_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic                fetch;
  logic                done;
  logic                accept;

  assign accept = valid_q & ready_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tgt_d   = tgt_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    fetch   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      DUMP_IDLE: begin
        if (start_i) begin
          state_d = DUMP_RUN;
          tgt_d   = target_i;
          idx_d   = '0;
        end
      end
      DUMP_RUN: begin
        // Output register may reload in the same cycle its word is taken.
        fetch = port_free_i & (~valid_q | ready_i);
        if (fetch) begin
          data_d  = rdata_i;
          valid_d = 1'b1;
          last_d  = (idx_q == LAST_IDX);
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = DUMP_FLUSH;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (accept) begin
          valid_d = 1'b0;
        end
      end
      DUMP_FLUSH: begin
        if (accept) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            done    = 1'b1;
            state_d = DUMP_IDLE;
          end
        end
      end
      default: state_d = DUMP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DUMP_IDLE;
      idx_q   <= '0;
      tgt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tgt_q   <= tgt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign fetch_o        = fetch;
  assign fetch_target_o = tgt_q;
  assign fetch_addr_o   = idx_q;
  assign busy_o         = (state_q != DUMP_IDLE);
  assign valid_o        = valid_q;
  assign data_o         = data_q;
  assign last_o         = last_q;
  assign done_o         = done;

endmodule

// File: rtl/sp_access_ctrl.sv
// Single-port scratchpad scheduler: engine writes beat host reads, which
// beat dump fetches; host read data is registered for one cycle.
module sp_access_ctrl #(
  parameter  int SP_NTARGETS = 4,
  parameter  int DATA_WIDTH  = 32,
  parameter  int BUS_WIDTH   = 64,
  localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
  localparam int N_WORDS     = MAX_DIM * MAX_DIM,
  localparam int ADDR_W      = 2 * $clog2(MAX_DIM),
  localparam int TGT_W       = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 eng_wr_req_i,
  input  logic [TGT_W-1:0]     eng_wr_target_i,
  input  logic [ADDR_W-1:0]    eng_wr_addr_i,
  input  logic [BUS_WIDTH-1:0] eng_wr_data_i,
  input  logic                 host_rd_req_i,
  input  logic [TGT_W-1:0]     host_rd_target_i,
  input  logic [ADDR_W-1:0]    host_rd_addr_i,
  output logic                 host_rd_gnt_o,
  output logic                 host_rd_valid_o,
  output logic [BUS_WIDTH-1:0] host_rd_data_o,
  input  logic                 dump_start_i,
  input  logic [TGT_W-1:0]     dump_target_i,
  output logic                 dump_busy_o,
  output logic                 dump_valid_o,
  input  logic                 dump_ready_i,
  output logic [BUS_WIDTH-1:0] dump_data_o,
  output logic                 dump_last_o,
  output logic                 dump_done_o,
  output logic                 sp_we_o,
  output logic [TGT_W-1:0]     sp_target_o,
  output logic [ADDR_W-1:0]    sp_addr_o,
  output logic [BUS_WIDTH-1:0] sp_wdata_o,
  input  logic [BUS_WIDTH-1:0] sp_rdata_i
);

  logic                 host_gnt;
  logic                 port_free;
  logic                 dump_fetch;
  logic [TGT_W-1:0]     dump_fetch_target;
  logic [ADDR_W-1:0]    dump_fetch_addr;
  logic                 host_valid_q, host_valid_d;
  logic [BUS_WIDTH-1:0] host_data_q, host_data_d;

  assign host_gnt  = host_rd_req_i & ~eng_wr_req_i;
  assign port_free = ~eng_wr_req_i & ~host_rd_req_i;

  sp_dump_fsm #(
    .WORD_W   (BUS_WIDTH),
    .IDX_W    (ADDR_W),
    .NUM_WORDS(N_WORDS),
    .TGT_BITS (TGT_W)
  ) u_dump_fsm (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (dump_start_i),
    .target_i      (dump_target_i),
    .port_free_i   (port_free),
    .ready_i       (dump_ready_i),
    .rdata_i       (sp_rdata_i),
    .fetch_o       (dump_fetch),
    .fetch_target_o(dump_fetch_target),
    .fetch_addr_o  (dump_fetch_addr),
    .busy_o        (dump_busy_o),
    .valid_o       (dump_valid_o),
    .data_o        (dump_data_o),
    .last_o        (dump_last_o),
    .done_o        (dump_done_o)
  );

  always_comb begin
    sp_we_o     = 1'b0;
    sp_target_o = '0;
    sp_addr_o   = '0;
    sp_wdata_o  = '0;
    if (eng_wr_req_i) begin
      sp_we_o     = 1'b1;
      sp_target_o = eng_wr_target_i;
      sp_addr_o   = eng_wr_addr_i;
      sp_wdata_o  = eng_wr_data_i;
    end else if (host_gnt) begin
      sp_target_o = host_rd_target_i;
      sp_addr_o   = host_rd_addr_i;
    end else if (dump_fetch) begin
      sp_target_o = dump_fetch_target;
      sp_addr_o   = dump_fetch_addr;
    end
  end

  always_comb begin
    host_valid_d = host_gnt;
    host_data_d  = host_gnt ? sp_rdata_i : host_data_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      host_valid_q <= 1'b0;
      host_data_q  <= '0;
    end else begin
      host_valid_q <= host_valid_d;
      host_data_q  <= host_data_d;
    end
  end

  assign host_rd_gnt_o   = host_gnt;
  assign host_rd_valid_o = host_valid_q;
  assign host_rd_data_o  = host_data_q;

endmodule
